// File: rtl/ysyx_23060332_regfile_sb.sv
// GPR file with NUM_RD read / NUM_WR write ports, same-cycle write->read
// bypass and a per-register busy scoreboard. IDU allocates destinations at
// issue; write-back ports deliver data and release the busy bit.
module ysyx_23060332_regfile_sb #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_WR  = 2,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr,
  output logic                       alloc_ready,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Per-register write decode: hit flag and data of the winning port
  logic [DEPTH-1:0]  wr_hit;
  logic [DATA_W-1:0] wr_sel [DEPTH];
  logic [DEPTH-1:0]  reg_we;
  logic              zero_alloc;

  // Resolve write ports per register; ascending scan lets the highest port win
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_sel[r] = '0;
    end
    for (int r = 0; r < DEPTH; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
          wr_hit[r] = 1'b1;
          wr_sel[r] = wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
    reg_we = wr_hit;
    if (ZERO_R0 != 0) begin
      reg_we[0] = 1'b0;
    end
  end

  // Next register contents
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = reg_we[r] ? wr_sel[r] : regs_q[r];
    end
  end

  // Alloc handshake: free register, register being released now, or hardwired x0
  always_comb begin
    zero_alloc  = (ZERO_R0 != 0) && (alloc_addr == '0);
    alloc_ready = !rst && (!busy_q[alloc_addr] || wr_hit[alloc_addr] || zero_alloc);
  end

  // Scoreboard update: a new allocation outranks a same-cycle release
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (alloc_en && alloc_ready && (alloc_addr == ADDR_W'(r)) &&
          !((ZERO_R0 != 0) && (r == 0))) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // Register array and scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: stored value, overridden by bypass, then by x0 and reset
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
      rd_busy[k]                  = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
      if ((BYPASS != 0) && wr_hit[rd_addr[k*ADDR_W +: ADDR_W]]) begin
        rd_data[k*DATA_W +: DATA_W] = wr_sel[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy[k]                  = 1'b0;
      end
      if ((ZERO_R0 != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end
      if (rst) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_ysyx_23060332_regfile_sb.sv
// Bench for ysyx_23060332_regfile_sb: a default build driven from a vector
// table through an expected-value queue, plus a BYPASS=0 / 3R1W build.
module tb_ysyx_23060332_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst;

  // Default build (2R2W, bypass, x0 hardwired)
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_ready;
  logic [31:0]     busy_vec;

  // No-bypass build (3R1W)
  logic [3*AW-1:0] b_rd_addr;
  logic [3*DW-1:0] b_rd_data;
  logic [2:0]      b_rd_busy;
  logic [0:0]      b_wr_en;
  logic [AW-1:0]   b_wr_addr;
  logic [DW-1:0]   b_wr_data;
  logic            b_alloc_en;
  logic [AW-1:0]   b_alloc_addr;
  logic            b_alloc_ready;
  logic [31:0]     b_busy_vec;

  int checks;
  int errors;

  ysyx_23060332_regfile_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .busy_vec(busy_vec)
  );

  ysyx_23060332_regfile_sb #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(3), .NUM_WR(1), .ZERO_R0(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .alloc_ready(b_alloc_ready),
    .busy_vec(b_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        ae;
    logic [4:0]  aa;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] x0;
    logic [31:0] x1;
    logic [1:0]  b;
    logic        ar;
    logic [31:0] bv;
  } vec_t;

  vec_t vecs [18];
  vec_t exp_q [$];

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
    input logic [4:0] a1, input logic [31:0] d1,
    input logic ae, input logic [4:0] aa,
    input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] x0, input logic [31:0] x1,
    input logic [1:0] b, input logic ar, input logic [31:0] bv);
    vec_t v;
    v.we = we; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.ae = ae; v.aa = aa; v.r0 = r0; v.r1 = r1;
    v.x0 = x0; v.x1 = x1; v.b = b; v.ar = ar; v.bv = bv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic idle_b();
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_alloc_en = 1'b0; b_alloc_addr = '0;
  endtask

  task automatic drive_a(input vec_t v);
    wr_en      = v.we;
    wr_addr    = {v.a1, v.a0};
    wr_data    = {v.d1, v.d0};
    alloc_en   = v.ae;
    alloc_addr = v.aa;
    rd_addr    = {v.r1, v.r0};
  endtask

  initial begin
    vec_t e;
    checks = 0;
    errors = 0;

    //          we     a0     d0            a1     d1            ae    aa     r0     r1     x0            x1            b      ar    bv
    vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 1'b1, 32'h0);
    vecs[1]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  5'd5,  5'd1,  32'hDEADBEEF, 32'h0,        2'b00, 1'b1, 32'h0);
    vecs[2]  = mk(2'b01, 5'd0, 32'h1234,     5'd0, 32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b1, 32'h0);
    vecs[3]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  5'd0,  5'd31, 32'h0,        32'h0,        2'b00, 1'b1, 32'h0);
    vecs[4]  = mk(2'b11, 5'd7, 32'h1,        5'd7, 32'h2,        1'b0, 5'd0,  5'd7,  5'd7,  32'h2,        32'h2,        2'b00, 1'b1, 32'h0);
    vecs[5]  = mk(2'b01, 5'd8, 32'h55,       5'd0, 32'h0,        1'b0, 5'd0,  5'd7,  5'd8,  32'h2,        32'h55,       2'b00, 1'b1, 32'h0);
    vecs[6]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd3,  5'd3,  5'd8,  32'h0,        32'h55,       2'b00, 1'b1, 32'h0);
    vecs[7]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,        32'h2,        2'b01, 1'b0, 32'h8);
    vecs[8]  = mk(2'b10, 5'd0, 32'h0,        5'd3, 32'hAA,       1'b0, 5'd3,  5'd3,  5'd3,  32'hAA,       32'hAA,       2'b00, 1'b1, 32'h8);
    vecs[9]  = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd3,  5'd3,  5'd0,  32'hAA,       32'h0,        2'b00, 1'b1, 32'h0);
    vecs[10] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd9,  5'd9,  5'd3,  32'h0,        32'hAA,       2'b00, 1'b1, 32'h0);
    vecs[11] = mk(2'b01, 5'd9, 32'h99,       5'd0, 32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       2'b00, 1'b1, 32'h200);
    vecs[12] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd9,  5'd9,  5'd3,  32'h99,       32'hAA,       2'b01, 1'b0, 32'h200);
    vecs[13] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        32'h99,       2'b10, 1'b1, 32'h200);
    vecs[14] = mk(2'b11, 5'd9, 32'h2222,     5'd9, 32'h1111,     1'b0, 5'd0,  5'd0,  5'd9,  32'h0,        32'h1111,     2'b00, 1'b1, 32'h200);
    vecs[15] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0,  5'd9,  5'd8,  32'h1111,     32'h55,       2'b00, 1'b1, 32'h0);
    vecs[16] = mk(2'b10, 5'd0, 32'h0,        5'd10, 32'hA5A5,    1'b1, 5'd11, 5'd10, 5'd11, 32'hA5A5,     32'h0,        2'b00, 1'b1, 32'h0);
    vecs[17] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd10, 5'd11, 5'd10, 32'h0,        32'hA5A5,     2'b01, 1'b1, 32'h800);

    // Held in reset: write/alloc/bypass must all be masked
    rst = 1'b1;
    idle_a();
    idle_b();
    #1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hCAFE};
    alloc_en = 1'b1; alloc_addr = 5'd6; rd_addr = {5'd6, 5'd5};
    @(negedge clk);
    check("rst rd0", rd_data[31:0], 32'h0);
    check("rst rd_busy", 32'(rd_busy), 32'h0);
    check("rst alloc_ready", 32'(alloc_ready), 32'h0);
    check("rst busy_vec", busy_vec, 32'h0);
    @(posedge clk);
    #1;
    idle_a();
    rst = 1'b0;
    #1;
    check("post-rst busy_vec", busy_vec, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'd0, 5'(i)};
      #1;
      check($sformatf("reset x%0d", i), rd_data[31:0], 32'h0);
    end

    // Vector table, expectations queued at drive time and retired at sample time
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      drive_a(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d rd0", i), rd_data[31:0], e.x0);
      check($sformatf("v%0d rd1", i), rd_data[63:32], e.x1);
      check($sformatf("v%0d rd_busy", i), 32'(rd_busy), 32'(e.b));
      check($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(e.ar));
      check($sformatf("v%0d busy_vec", i), busy_vec, e.bv);
      @(posedge clk);
      #1;
    end
    check("queue drained", 32'(exp_q.size()), 32'h0);

    // Mid-run reset: x11 busy, x10 holds data; both must vanish immediately
    idle_a();
    rd_addr = {5'd11, 5'd10};
    alloc_en = 1'b1; alloc_addr = 5'd12;
    #1;
    check("pre-rst rd0", rd_data[31:0], 32'hA5A5);
    check("pre-rst rd_busy", 32'(rd_busy), 32'h2);
    rst = 1'b1;
    #1;
    check("mid-rst rd0", rd_data[31:0], 32'h0);
    check("mid-rst rd_busy", 32'(rd_busy), 32'h0);
    check("mid-rst alloc_ready", 32'(alloc_ready), 32'h0);
    check("mid-rst busy_vec", busy_vec, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    alloc_en = 1'b0;
    #1;
    check("after-rst x10", rd_data[31:0], 32'h0);
    check("after-rst busy_vec", busy_vec, 32'h0);
    // Stale write-back to x11 after release lands normally
    wr_en = 2'b10; wr_addr = {5'd11, 5'd0}; wr_data = {32'h77, 32'h0};
    @(posedge clk);
    #1;
    idle_a();
    rd_addr = {5'd0, 5'd11};
    #1;
    check("late wb x11", rd_data[31:0], 32'h77);
    check("late wb busy_vec", busy_vec, 32'h0);

    // No-bypass build: same-cycle write reads old value, new value next cycle
    b_wr_en = 1'b1; b_wr_addr = 5'd4; b_wr_data = 32'h33;
    @(posedge clk);
    #1;
    idle_b();
    b_alloc_en = 1'b1; b_alloc_addr = 5'd4;
    #1;
    check("nb alloc_ready", 32'(b_alloc_ready), 32'h1);
    @(posedge clk);
    #1;
    idle_b();
    b_wr_en = 1'b1; b_wr_addr = 5'd4; b_wr_data = 32'h44;
    b_alloc_addr = 5'd4;
    b_rd_addr = {5'd0, 5'd4, 5'd4};
    #1;
    check("nb busy_vec", b_busy_vec, 32'h10);
    check("nb old rd0", b_rd_data[31:0], 32'h33);
    check("nb old rd1", b_rd_data[63:32], 32'h33);
    check("nb x0 rd2", b_rd_data[95:64], 32'h0);
    check("nb rd_busy", 32'(b_rd_busy), 32'h3);
    check("nb alloc_ready on wb", 32'(b_alloc_ready), 32'h1);
    @(posedge clk);
    #1;
    b_wr_en = 1'b0;
    #1;
    check("nb new rd0", b_rd_data[31:0], 32'h44);
    check("nb new rd_busy", 32'(b_rd_busy), 32'h0);
    check("nb cleared busy_vec", b_busy_vec, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
